hier_rr_aggregator: RTL and testbench

HIER_RR_AGGREGATOR -- requirements
Module: hier_rr_aggregator

---
 rtl/hier_agg_pkg.sv | 12 +
 rtl/hier_ch_fifo.sv | 66 ++++++
 rtl/hier_rr_aggregator.sv | 110 +++++++++++
 tb/tb_hier_rr_aggregator.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hier_agg_pkg.sv
// Shared width helpers for the hierarchical round-robin aggregator.
package hier_agg_pkg;

  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 32'sd2) ? $clog2(num_ch) : 32'sd1;
  endfunction

  function automatic int level_w(input int fifo_depth);
    return $clog2(fifo_depth + 32'sd1);
  endfunction

endpackage

// File: rtl/hier_ch_fifo.sv
// Per-channel FIFO with registered occupancy; push/pop are self-guarded
// against full/empty so a stray request can never corrupt the pointers.
module hier_ch_fifo
  import hier_agg_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push,
  input  logic                             pop,
  input  logic [DATA_W-1:0]                din,
  output logic [DATA_W-1:0]                dout,
  output logic                             full,
  output logic                             empty,
  output logic [level_w(FIFO_DEPTH)-1:0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = level_w(FIFO_DEPTH);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [LW-1:0]     level_r;
  logic              push_s;
  logic              pop_s;

  assign push_s = push & ~full;
  assign pop_s  = pop & ~empty;
  assign full   = (level_r == LEVEL_FULL);
  assign empty  = (level_r == LW'(0));
  assign dout   = mem_r[rd_ptr_r];
  assign level  = level_r;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/hier_rr_aggregator.sv
// Aggregates NUM_CH buffered channels into one stream through a round-robin
// arbiter feeding a single registered output stage.
module hier_rr_aggregator
  import hier_agg_pkg::*;
#(
  parameter int NUM_CH     = 5,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_CH-1:0]                       in_valid,
  input  logic [NUM_CH*DATA_W-1:0]                in_data,
  output logic [NUM_CH-1:0]                       in_ready,
  input  logic [NUM_CH-1:0]                       ch_en,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [DATA_W-1:0]                       out_data,
  output logic [ch_idx_w(NUM_CH)-1:0]             out_ch,
  output logic [NUM_CH*level_w(FIFO_DEPTH)-1:0]   ch_level
);

  localparam int CW = ch_idx_w(NUM_CH);
  localparam int LW = level_w(FIFO_DEPTH);

  logic [NUM_CH-1:0] full_s;
  logic [NUM_CH-1:0] empty_s;
  logic [NUM_CH-1:0] push_s;
  logic [NUM_CH-1:0] pop_s;
  logic [NUM_CH-1:0] eligible_s;
  logic [DATA_W-1:0] head_s [NUM_CH];
  logic              loadable_s;
  logic              grant_valid_s;
  logic [CW-1:0]     grant_idx_s;
  logic [CW-1:0]     idx_s;
  int                sum_s;

  logic              out_valid_r;
  logic [DATA_W-1:0] out_data_r;
  logic [CW-1:0]     out_ch_r;
  logic [CW-1:0]     rr_ptr_r;

  assign in_ready   = ~full_s;
  assign push_s     = in_valid & ~full_s;
  assign eligible_s = ~empty_s & ch_en;
  assign loadable_s = ~out_valid_r | out_ready;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign pop_s[g] = loadable_s & grant_valid_s & (grant_idx_s == CW'(g));

    hier_ch_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_s[g]),
      .pop   (pop_s[g]),
      .din   (in_data[g*DATA_W +: DATA_W]),
      .dout  (head_s[g]),
      .full  (full_s[g]),
      .empty (empty_s[g]),
      .level (ch_level[g*LW +: LW])
    );
  end

  // Round-robin search: first eligible channel at or above rr_ptr, wrapping.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_idx_s   = '0;
    idx_s         = '0;
    sum_s         = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      sum_s = (int'(rr_ptr_r) + k >= NUM_CH) ? int'(rr_ptr_r) + k - NUM_CH
                                             : int'(rr_ptr_r) + k;
      idx_s = CW'(sum_s);
      if (!grant_valid_s && eligible_s[idx_s]) begin
        grant_valid_s = 1'b1;
        grant_idx_s   = idx_s;
      end else begin
        grant_idx_s   = grant_idx_s;
      end
    end
  end

  // Output register and rotating priority pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_ch_r    <= '0;
      rr_ptr_r    <= '0;
    end else if (loadable_s) begin
      if (grant_valid_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= head_s[grant_idx_s];
        out_ch_r    <= grant_idx_s;
        rr_ptr_r    <= (grant_idx_s == CW'(NUM_CH - 1)) ? CW'(0)
                                                        : grant_idx_s + CW'(1);
      end else begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_ch    = out_ch_r;

endmodule

// File: tb/tb_hier_rr_aggregator.sv
// Directed and random checks of hier_rr_aggregator against a queue-based
// reference model of the channel buffers, arbiter and output stage.
module tb_hier_rr_aggregator;

  localparam int N  = 5;
  localparam int DW = 32;
  localparam int D  = 4;
  localparam int CW = 3;
  localparam int LW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_ready;
  logic [N-1:0]    ch_en;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [CW-1:0]   out_ch;
  logic [N*LW-1:0] ch_level;

  int n_assert = 0;
  int n_fail   = 0;

  logic [DW-1:0] q [N][$];
  bit            m_ov;
  logic [DW-1:0] m_od;
  int            m_oc;
  int            m_ptr;
  int            log_ch[$];
  logic [DW-1:0] log_d[$];
  int            cnt;

  always #5 clk = ~clk;

  hier_rr_aggregator #(.NUM_CH(N), .DATA_W(DW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ch_en(ch_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
    .ch_level(ch_level)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int ch, input logic [DW-1:0] v);
    in_data[ch*DW +: DW] = v;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) q[i].delete();
    m_ov = 1'b0; m_od = '0; m_oc = 0; m_ptr = 0;
  endtask

  // One clock edge of the reference behaviour, using pre-edge occupancy.
  task automatic model_step();
    logic [N-1:0] rdy;
    bit found;
    int g;
    int idx;
    found = 1'b0; g = 0;
    for (int i = 0; i < N; i++) rdy[i] = (q[i].size() < D);
    if (!m_ov || out_ready) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (!found && q[idx].size() > 0 && ch_en[idx]) begin
          found = 1'b1; g = idx;
        end
      end
      if (found) begin
        m_od = q[g].pop_front(); m_oc = g; m_ov = 1'b1; m_ptr = (g + 1) % N;
      end else begin
        m_ov = 1'b0;
      end
    end
    for (int i = 0; i < N; i++)
      if (in_valid[i] && rdy[i]) q[i].push_back(in_data[i*DW +: DW]);
  endtask

  task automatic compare();
    logic [N*LW-1:0] exp_lvl;
    logic [N-1:0]    exp_rdy;
    for (int i = 0; i < N; i++) begin
      exp_lvl[i*LW +: LW] = LW'(q[i].size());
      exp_rdy[i] = (q[i].size() < D);
    end
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    if (m_ov) begin
      chk("out_data", 64'(out_data), 64'(m_od));
      chk("out_ch", 64'(out_ch), 64'(m_oc));
    end
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("ch_level", 64'(ch_level), 64'(exp_lvl));
  endtask

  // Called with clk low: check, log any handshake, advance one edge.
  task automatic cycle();
    compare();
    if (out_valid === 1'b1 && out_ready) begin
      log_ch.push_back(int'(out_ch));
      log_d.push_back(out_data);
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = '0; out_ready = 1'b0; ch_en = '1;
    model_reset();
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_ch_level", 64'(ch_level), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    log_ch.delete(); log_d.delete();
  endtask

  function automatic int count_ch(input int ch);
    int c;
    c = 0;
    foreach (log_ch[i]) if (log_ch[i] == ch) c++;
    return c;
  endfunction

  initial begin
    int exp_seq[10];
    exp_seq = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};
    rst_n = 1'b0; in_valid = '0; in_data = '0; ch_en = '1; out_ready = 1'b0;
    model_reset();
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_data", 64'(out_data), 64'd0);
    chk("reset_out_ch", 64'(out_ch), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'h1f);
    chk("reset_ch_level", 64'(ch_level), 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // single word on ch3, 2-cycle latency
    out_ready = 1'b1;
    in_valid = 5'b01000; set_data(3, 32'hA5);
    cycle();
    in_valid = '0;
    chk("single_c1_valid", 64'(out_valid), 64'd0);
    cycle();
    chk("single_c2_valid", 64'(out_valid), 64'd1);
    chk("single_c2_data", 64'(out_data), 64'hA5);
    chk("single_c2_ch", 64'(out_ch), 64'd3);
    cycle();
    chk("single_level3", 64'(ch_level[3*LW +: LW]), 64'd0);

    // wrap: pointer now 4, only ch0 and ch4 eligible
    log_ch.delete(); log_d.delete();
    in_valid = 5'b10001; set_data(0, 32'h0C0); set_data(4, 32'h0C4);
    cycle();
    in_valid = '0;
    repeat (4) cycle();
    chk("wrap_count", 64'(log_ch.size()), 64'd2);
    chk("wrap_first", 64'(log_ch.size() > 0 ? log_ch[0] : -1), 64'd4);
    chk("wrap_second", 64'(log_ch.size() > 1 ? log_ch[1] : -1), 64'd0);

    // fairness: two words on every channel
    do_reset();
    in_valid = '1;
    for (int i = 0; i < N; i++) set_data(i, 32'h10 + 32'(i));
    cycle();
    for (int i = 0; i < N; i++) set_data(i, 32'h20 + 32'(i));
    cycle();
    in_valid = '0;
    cycle();
    out_ready = 1'b1;
    repeat (12) cycle();
    chk("fair_count", 64'(log_ch.size()), 64'd10);
    for (int i = 0; i < 10; i++)
      chk("fair_seq", 64'(i < log_ch.size() ? log_ch[i] : -1), 64'(exp_seq[i]));
    chk("fair_drained", 64'(out_valid), 64'd0);

    // backpressure on ch1
    do_reset();
    in_valid = 5'b00010;
    for (int k = 0; k < 10; k++) begin
      set_data(1, 32'h100 + 32'(k));
      cycle();
    end
    in_valid = '0;
    chk("bp_level1", 64'(ch_level[1*LW +: LW]), 64'd4);
    chk("bp_ready1", 64'(in_ready[1]), 64'd0);
    chk("bp_held_data", 64'(out_data), 64'h100);
    out_ready = 1'b1;
    repeat (8) cycle();
    chk("bp_count", 64'(log_d.size()), 64'd5);
    for (int k = 0; k < 5; k++)
      chk("bp_order", 64'(k < log_d.size() ? log_d[k] : 32'hFFFF_FFFF), 64'(32'h100 + 32'(k)));

    // mask ch2 then release it
    do_reset();
    ch_en = 5'b11011;
    in_valid = '1;
    for (int i = 0; i < N; i++) set_data(i, 32'h300 + 32'(i));
    cycle();
    for (int i = 0; i < N; i++) set_data(i, 32'h310 + 32'(i));
    cycle();
    in_valid = '0;
    out_ready = 1'b1;
    repeat (10) cycle();
    chk("mask_ch2_never", 64'(count_ch(2)), 64'd0);
    chk("mask_ch2_held", 64'(ch_level[2*LW +: LW]), 64'd2);
    ch_en = '1;
    repeat (6) cycle();
    cnt = count_ch(2);
    chk("mask_ch2_drained", 64'(cnt), 64'd2);
    chk("mask_level2", 64'(ch_level[2*LW +: LW]), 64'd0);

    // asynchronous reset mid-operation
    out_ready = 1'b0;
    in_valid = 5'b00111;
    for (int i = 0; i < 3; i++) set_data(i, 32'h400 + 32'(i));
    cycle();
    in_valid = '0;
    cycle();
    chk("mid_pre_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_out_valid", 64'(out_valid), 64'd0);
    chk("mid_ch_level", 64'(ch_level), 64'd0);
    chk("mid_in_ready", 64'(in_ready), 64'h1f);
    in_valid = '1; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("mid_ignore_push", 64'(ch_level), 64'd0);
    chk("mid_ignore_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    in_valid = '0; rst_n = 1'b1;
    log_ch.delete(); log_d.delete();
    repeat (4) cycle();
    chk("mid_nothing_after", 64'(log_d.size()), 64'd0);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      in_valid  = N'($urandom);
      for (int i = 0; i < N; i++) set_data(i, $urandom);
      ch_en     = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    in_valid = '0; ch_en = '1; out_ready = 1'b1;
    repeat (30) cycle();
    chk("final_empty", 64'(ch_level), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
